vram_access: RTL and testbench

- Sits directly downstream of the host-bus control block and executes its internal commands against the 16-bit character/attribute VRAM (one UP5K SPRAM port).
- Consumes the control block's int_command, int_address and int_data_out, and returns state and read data.
- Shares the single VRAM port with the display scan-out reader; display always has priority.
- Executes single-word read, single-word write and a multi-cycle screen clear.

---
 rtl/vram_access_pkg.sv | 29 ++
 rtl/vram_access.sv | 119 +++++++++++
 tb/tb_vram_access.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vram_access_pkg.sv
// Shared command/state codes for the host control path and the VRAM access engine.
// FSM encodings live here so the control block can decode engine state the same way.
package vram_access_pkg;

    localparam logic [5:0] CMD_NONE    = 6'b000000;
    localparam logic [5:0] CMD_RD_CHAR = 6'b010011;
    localparam logic [5:0] CMD_WR_CHAR = 6'b100011;
    localparam logic [5:0] CMD_CLEAR   = 6'b110000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] FSM_IDLE   = 3'd0;
    localparam logic [2:0] FSM_EXEC   = 3'd1;
    localparam logic [2:0] FSM_RD_CAP = 3'd2;
    localparam logic [2:0] FSM_CLR    = 3'd3;
    localparam logic [2:0] FSM_DONE   = 3'd4;

    // Host-visible status for a given internal FSM state.
    function automatic logic [1:0] host_state(input logic [2:0] fsm);
        case (fsm)
            FSM_IDLE: host_state = ST_IDLE;
            FSM_DONE: host_state = ST_DONE;
            default:  host_state = ST_BUSY;
        endcase
    endfunction

endpackage

// File: rtl/vram_access.sv
// Executes host read/write/clear commands on the single-port character VRAM,
// yielding the port to the display scan-out reader whenever it requests it.
module vram_access
    import vram_access_pkg::*;
#(
    parameter int          ADDR_W       = 14,
    parameter int          SCREEN_WORDS = 2400,
    parameter logic [15:0] CLEAR_WORD   = 16'h7020
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [5:0]        cmd,
    input  logic [15:0]       cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic [15:0]       cmd_rdata,
    output logic [1:0]        state,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [15:0]       disp_data,
    output logic              disp_valid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_wdata,
    output logic              vram_we,
    input  logic [15:0]       vram_rdata
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SCREEN_WORDS - 1);

    logic [2:0]        fsm;
    logic [5:0]        lat_cmd;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_data;
    logic [ADDR_W-1:0] clr_cnt;
    logic [15:0]       disp_hold;
    logic              addr_unused;

    assign addr_unused = ^cmd_addr[15:ADDR_W];
    assign state       = host_state(fsm);

    // Display data is live on the valid cycle and held afterwards.
    assign disp_data = disp_valid ? vram_rdata : disp_hold;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm        <= FSM_IDLE;
            lat_cmd    <= CMD_NONE;
            lat_addr   <= '0;
            lat_data   <= '0;
            clr_cnt    <= '0;
            cmd_rdata  <= '0;
            disp_valid <= 1'b0;
            disp_hold  <= '0;
        end else begin
            disp_valid <= disp_req;
            if (disp_valid)
                disp_hold <= vram_rdata;

            case (fsm)
                FSM_IDLE: begin
                    if (cmd != CMD_NONE) begin
                        lat_cmd  <= cmd;
                        lat_addr <= cmd_addr[ADDR_W-1:0];
                        lat_data <= cmd_wdata;
                        clr_cnt  <= '0;
                        fsm      <= (cmd == CMD_CLEAR) ? FSM_CLR : FSM_EXEC;
                    end
                end
                FSM_EXEC: begin
                    // Unsupported codes fall through to DONE without touching VRAM.
                    if (!disp_req)
                        fsm <= (lat_cmd == CMD_RD_CHAR) ? FSM_RD_CAP : FSM_DONE;
                end
                FSM_RD_CAP: begin
                    cmd_rdata <= vram_rdata;
                    fsm       <= FSM_DONE;
                end
                FSM_CLR: begin
                    if (!disp_req) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == CLR_LAST)
                            fsm <= FSM_DONE;
                    end
                end
                FSM_DONE: begin
                    if (cmd == CMD_NONE)
                        fsm <= FSM_IDLE;
                end
                default: fsm <= FSM_IDLE;
            endcase
        end
    end

    always_comb begin
        vram_addr  = '0;
        vram_wdata = lat_data;
        vram_we    = 1'b0;
        if (disp_req) begin
            vram_addr = disp_addr;
        end else begin
            case (fsm)
                FSM_EXEC: begin
                    if (lat_cmd == CMD_RD_CHAR) begin
                        vram_addr = lat_addr;
                    end else if (lat_cmd == CMD_WR_CHAR) begin
                        vram_addr = lat_addr;
                        vram_we   = 1'b1;
                    end
                end
                FSM_CLR: begin
                    vram_addr  = clr_cnt;
                    vram_wdata = CLEAR_WORD;
                    vram_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_access.sv
// Directed bench for vram_access: table of single commands, then display
// contention, a full clear with display stalls, and a reset in mid-clear.
module tb_vram_access;
    import vram_access_pkg::*;

    localparam int ADDR_W = 14;
    localparam int SW     = 2400;

    logic              clk = 1'b0;
    logic              nrst;
    logic [5:0]        cmd;
    logic [15:0]       cmd_addr, cmd_wdata, cmd_rdata;
    logic [1:0]        state;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [15:0]       disp_data;
    logic              disp_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_wdata;
    logic              vram_we;
    logic [15:0]       vram_rdata;

    logic [15:0] mem [0:(1<<ADDR_W)-1];
    int          wr_cnt = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    vram_access #(.ADDR_W(ADDR_W), .SCREEN_WORDS(SW), .CLEAR_WORD(16'h7020)) dut (
        .clk(clk), .nrst(nrst), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_rdata(cmd_rdata), .state(state), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    // SPRAM model: synchronous write, registered read one cycle after the address.
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
        wr_cnt     <= wr_cnt + (vram_we ? 1 : 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [5:0] c, input logic [15:0] a, input logic [15:0] d,
                           input int hold, output int lat, output int wr);
        int w0, busy_at;
        w0 = wr_cnt;
        lat = -1;
        busy_at = -1;
        @(negedge clk);
        cmd = c; cmd_addr = a; cmd_wdata = d;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (state == ST_BUSY && busy_at < 0) busy_at = i;
            if (state == ST_DONE) begin
                lat = (busy_at < 0) ? -2 : i - busy_at;
                break;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("done_hold_state", 32'(state), 32'(ST_DONE));
        end
        wr = wr_cnt - w0;
        cmd = CMD_NONE;
        @(negedge clk);
        chk("return_idle", 32'(state), 32'(ST_IDLE));
    endtask

    typedef struct {
        logic [5:0]  c;
        logic [15:0] a;
        logic [15:0] d;
        int          hold;
        int          lat;
        int          wr;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int lat, wr, w0, busy_at, bad;

        tbl[0]  = '{CMD_WR_CHAR, 16'h0005, 16'h7041, 5, 1, 1, 16'h0000};
        tbl[1]  = '{CMD_RD_CHAR, 16'h0005, 16'h0000, 0, 2, 0, 16'h7041};
        tbl[2]  = '{CMD_WR_CHAR, 16'h3FFF, 16'hABCD, 0, 1, 1, 16'h7041};
        tbl[3]  = '{CMD_WR_CHAR, 16'hC123, 16'h1234, 0, 1, 1, 16'h7041};
        tbl[4]  = '{CMD_RD_CHAR, 16'h0123, 16'h0000, 0, 2, 0, 16'h1234};
        tbl[5]  = '{CMD_RD_CHAR, 16'hFFFF, 16'h0000, 3, 2, 0, 16'hABCD};
        tbl[6]  = '{CMD_WR_CHAR, 16'h0960, 16'hBEEF, 0, 1, 1, 16'hABCD};
        tbl[7]  = '{6'b100101,   16'h0005, 16'hFFFF, 0, 1, 0, 16'hABCD};
        tbl[8]  = '{6'b000001,   16'h0005, 16'hFFFF, 2, 1, 0, 16'hABCD};
        tbl[9]  = '{CMD_RD_CHAR, 16'h0960, 16'h0000, 0, 2, 0, 16'hBEEF};
        tbl[10] = '{CMD_WR_CHAR, 16'h0000, 16'h1111, 0, 1, 1, 16'hBEEF};

        nrst = 1'b0; cmd = '0; cmd_addr = '0; cmd_wdata = '0; disp_req = 1'b0; disp_addr = '0;
        #1;
        chk("rst_state", 32'(state), 32'(ST_IDLE));
        chk("rst_rdata", 32'(cmd_rdata), 32'h0);
        chk("rst_disp_valid", 32'(disp_valid), 32'h0);
        chk("rst_disp_data", 32'(disp_data), 32'h0);
        chk("rst_we", 32'(vram_we), 32'h0);
        chk("rst_addr", 32'(vram_addr), 32'h0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        for (int v = 0; v < 11; v++) begin
            run_cmd(tbl[v].c, tbl[v].a, tbl[v].d, tbl[v].hold, lat, wr);
            chk($sformatf("v%0d_latency", v), 32'(lat), 32'(tbl[v].lat));
            chk($sformatf("v%0d_writes", v), 32'(wr), 32'(tbl[v].wr));
            chk($sformatf("v%0d_rdata", v), 32'(cmd_rdata), 32'(tbl[v].rd));
            if (tbl[v].c == CMD_WR_CHAR)
                chk($sformatf("v%0d_mem", v), 32'(mem[tbl[v].a[13:0]]), 32'(tbl[v].d));
        end

        // Write held off by three display cycles; each display read returns its own word.
        @(negedge clk);
        cmd = CMD_WR_CHAR; cmd_addr = 16'h0010; cmd_wdata = 16'h5555;
        @(negedge clk);
        chk("ct_busy1", 32'(state), 32'(ST_BUSY));
        disp_req = 1'b1; disp_addr = 14'h0005; #1;
        chk("ct_we1", 32'(vram_we), 32'h0);
        chk("ct_addr1", 32'(vram_addr), 32'h0005);
        @(negedge clk);
        chk("ct_valid1", 32'(disp_valid), 32'h1);
        chk("ct_data1", 32'(disp_data), 32'h7041);
        disp_addr = 14'h3FFF; #1;
        chk("ct_we2", 32'(vram_we), 32'h0);
        @(negedge clk);
        chk("ct_data2", 32'(disp_data), 32'hABCD);
        disp_addr = 14'h0123; #1;
        chk("ct_we3", 32'(vram_we), 32'h0);
        @(negedge clk);
        chk("ct_data3", 32'(disp_data), 32'h1234);
        chk("ct_busy4", 32'(state), 32'(ST_BUSY));
        disp_req = 1'b0; #1;
        chk("ct_we4", 32'(vram_we), 32'h1);
        chk("ct_addr4", 32'(vram_addr), 32'h0010);
        chk("ct_wdata4", 32'(vram_wdata), 32'h5555);
        @(negedge clk);
        chk("ct_done", 32'(state), 32'(ST_DONE));
        chk("ct_valid_drop", 32'(disp_valid), 32'h0);
        chk("ct_mem", 32'(mem[16'h0010]), 32'h5555);
        cmd = CMD_NONE;
        @(negedge clk);
        chk("ct_idle", 32'(state), 32'(ST_IDLE));

        // Full clear with two display stall cycles in the middle.
        w0 = wr_cnt; lat = -1; busy_at = -1;
        @(negedge clk);
        cmd = CMD_CLEAR;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (state == ST_BUSY && busy_at < 0) busy_at = i;
            if (state == ST_DONE) begin
                lat = i - busy_at;
                break;
            end
            disp_req = (i == 50 || i == 51);
        end
        disp_req = 1'b0;
        chk("clr_latency", 32'(lat), 32'(SW + 2));
        chk("clr_writes", 32'(wr_cnt - w0), 32'(SW));
        bad = 0;
        for (int i = 0; i < SW; i++)
            if (mem[i] !== 16'h7020) bad++;
        chk("clr_fill_bad", 32'(bad), 32'h0);
        chk("clr_untouched_2400", 32'(mem[SW]), 32'hBEEF);
        cmd = CMD_NONE;
        @(negedge clk);
        chk("clr_idle", 32'(state), 32'(ST_IDLE));

        // Reset asserted while the clear is about to write address 100.
        w0 = wr_cnt;
        @(negedge clk);
        cmd = CMD_CLEAR;
        bad = 1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (vram_we && vram_addr == 14'd100) begin
                bad = 0;
                break;
            end
        end
        chk("mid_reached_100", 32'(bad), 32'h0);
        chk("mid_writes_before", 32'(wr_cnt - w0), 32'd100);
        w0 = wr_cnt;
        nrst = 1'b0; cmd = CMD_NONE; #1;
        chk("mid_state", 32'(state), 32'(ST_IDLE));
        chk("mid_we", 32'(vram_we), 32'h0);
        chk("mid_rdata", 32'(cmd_rdata), 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("mid_no_more_writes", 32'(wr_cnt - w0), 32'h0);
        chk("mid_state_after", 32'(state), 32'(ST_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
